// File: rtl/zap_btb_pkg.sv
// Shared types and width derivations for the BTB maintenance logic.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package zap_btb_pkg;

    // Maintenance controller states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } maint_state_t;

    // Default BTB geometry. The tag covers the PC bits above the index,
    // less bit 0 (Thumb bit is never part of the tag).
    localparam int DFLT_ENTRIES  = 1024;
    localparam int TAG_WDT       = 32 - $clog2(DFLT_ENTRIES) - 1;
    // Full RAM word: 32-bit target + tag + 2-bit branch state.
    localparam int MAX_WDT       = 32 + TAG_WDT + 2;
    // Feedback queue depth.
    localparam int FB_FIFO_DEPTH = 4;

endpackage

// File: rtl/zap_sync_fifo.sv
// Small synchronous FIFO with flush-style clear.
// Latency: a pushed word is visible on o_rdata the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module zap_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == FULL_CNT);
    assign o_rdata = r_mem[r_rptr];

    // Pointer and occupancy tracking; clear empties the queue in one cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage array, not reset: contents are only meaningful below r_cnt.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wptr] <= i_wdata;
    end

endmodule

// File: rtl/zap_btb_maint_ctrl.sv
// BTB maintenance: full-table invalidation sweep and queued feedback writes.
// Latency: feedback accepted at edge N is on the registered write port after edge N+1.
// Backpressure: i_wr_hold stalls all writes; feedback refused (and dropped) when busy or queue full.
module zap_btb_maint_ctrl
    import zap_btb_pkg::*;
#(
    parameter int BP_ENTRIES = 32'd1024,
    parameter int WR_WDT     = MAX_WDT
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_flush_req,
    input  logic                          i_wr_hold,
    input  logic                          i_fb_valid,
    input  logic [$clog2(BP_ENTRIES)-1:0] i_fb_index,
    input  logic [WR_WDT-1:0]             i_fb_wdata,
    output logic                          o_fb_ready,
    output logic                          o_fb_drop,
    output logic                          o_wr_en,
    output logic [$clog2(BP_ENTRIES)-1:0] o_wr_addr,
    output logic [WR_WDT-1:0]             o_wr_data,
    output logic                          o_wr_dav,
    output logic                          o_flush_busy,
    output logic                          o_flush_done
);
    localparam int IDX_W  = $clog2(BP_ENTRIES);
    localparam int FIFO_W = IDX_W + WR_WDT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BP_ENTRIES - 1);

    maint_state_t      r_state;
    maint_state_t      w_state_nxt;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  w_cnt_nxt;

    logic              r_wr_en;
    logic [IDX_W-1:0]  r_wr_addr;
    logic [WR_WDT-1:0] r_wr_data;
    logic              r_wr_dav;
    logic              r_fb_drop;

    logic              w_wr_issue;
    logic [IDX_W-1:0]  w_wr_addr;
    logic [WR_WDT-1:0] w_wr_data;
    logic              w_wr_dav;

    logic              w_fb_ready;
    logic              w_fifo_push;
    logic              w_fifo_pop;
    logic              w_fifo_clear;
    logic [FIFO_W-1:0] w_fifo_rdata;
    logic              w_fifo_empty;
    logic              w_fifo_full;

    // Feedback is only taken while idle and no flush is starting this cycle.
    assign w_fb_ready  = (r_state == ST_IDLE) & ~i_flush_req & ~w_fifo_full;
    assign w_fifo_push = i_fb_valid & w_fb_ready;

    zap_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FB_FIFO_DEPTH)
    ) u_fb_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_fifo_clear),
        .i_push  (w_fifo_push),
        .i_wdata ({i_fb_index, i_fb_wdata}),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_fifo_rdata),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full)
    );

    // State and sweep-index registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state and write selection; a pending flush request suppresses the pop
    // so queued feedback is discarded rather than racing the invalidation.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_wr_issue   = 1'b0;
        w_wr_addr    = r_cnt;
        w_wr_data    = '0;
        w_wr_dav     = 1'b0;
        w_fifo_clear = 1'b0;
        w_fifo_pop   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_flush_req) begin
                    w_state_nxt  = ST_FLUSH;
                    w_fifo_clear = 1'b1;
                    w_cnt_nxt    = '0;
                end else if (!w_fifo_empty && !i_wr_hold) begin
                    w_fifo_pop = 1'b1;
                    w_wr_issue = 1'b1;
                    w_wr_addr  = w_fifo_rdata[FIFO_W-1 -: IDX_W];
                    w_wr_data  = w_fifo_rdata[WR_WDT-1:0];
                    w_wr_dav   = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (!i_wr_hold) begin
                    w_wr_issue = 1'b1;
                    w_cnt_nxt  = r_cnt + 1'b1;
                    if (r_cnt == LAST_IDX) w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Registered RAM write port; address/data hold when no write is issued.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_dav  <= 1'b0;
            r_fb_drop <= 1'b0;
        end else begin
            r_wr_en   <= w_wr_issue;
            r_fb_drop <= i_fb_valid & ~w_fb_ready;
            if (w_wr_issue) begin
                r_wr_addr <= w_wr_addr;
                r_wr_data <= w_wr_data;
                r_wr_dav  <= w_wr_dav;
            end
        end
    end

    assign o_fb_ready   = w_fb_ready;
    assign o_fb_drop    = r_fb_drop;
    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_wr_dav     = r_wr_dav;
    assign o_flush_busy = (r_state != ST_IDLE);
    assign o_flush_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_zap_btb_maint_ctrl.sv
// Directed and randomized checks of the BTB maintenance controller (8 entries).
// Latency: n/a.
// Backpressure: n/a.
module tb_zap_btb_maint_ctrl;

    localparam int ENT = 8;
    localparam int WD  = 55;

    typedef struct {
        int          cyc;
        logic [2:0]  addr;
        logic [54:0] data;
        logic        dav;
    } wr_rec_t;

    typedef struct {
        logic [2:0]  idx;
        logic [54:0] dat;
    } fb_t;

    logic          i_clk = 1'b0;
    logic          i_reset;
    logic          i_flush_req;
    logic          i_wr_hold;
    logic          i_fb_valid;
    logic [2:0]    i_fb_index;
    logic [WD-1:0] i_fb_wdata;
    logic          o_fb_ready;
    logic          o_fb_drop;
    logic          o_wr_en;
    logic [2:0]    o_wr_addr;
    logic [WD-1:0] o_wr_data;
    logic          o_wr_dav;
    logic          o_flush_busy;
    logic          o_flush_done;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int drop_cnt = 0;
    wr_rec_t obs_q[$];
    wr_rec_t mon_rec;

    zap_btb_maint_ctrl #(
        .BP_ENTRIES (ENT),
        .WR_WDT     (WD)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_flush_req  (i_flush_req),
        .i_wr_hold    (i_wr_hold),
        .i_fb_valid   (i_fb_valid),
        .i_fb_index   (i_fb_index),
        .i_fb_wdata   (i_fb_wdata),
        .o_fb_ready   (o_fb_ready),
        .o_fb_drop    (o_fb_drop),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_wr_dav     (o_wr_dav),
        .o_flush_busy (o_flush_busy),
        .o_flush_done (o_flush_done)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    // Passive monitor: logs every write and counts busy/done/drop cycles.
    always @(negedge i_clk) begin
        if (o_wr_en) begin
            mon_rec.cyc  = cyc;
            mon_rec.addr = o_wr_addr;
            mon_rec.data = o_wr_data;
            mon_rec.dav  = o_wr_dav;
            obs_q.push_back(mon_rec);
        end
        if (o_flush_busy) busy_cnt++;
        if (o_flush_done) done_cnt++;
        if (o_fb_drop)    drop_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40; k++) begin
            if (!o_flush_busy) break;
            tick();
        end
        chk(tag, 64'(o_flush_busy), 64'(0));
    endtask

    int      n0, b0, d0, r0, nd;
    fb_t     mq[$];
    fb_t     fe;
    int      ph, nxt;
    logic    m_ready, e_wr, e_dav, e_drop;
    logic [2:0]  e_addr, last_addr;
    logic [54:0] e_data, last_data;

    initial begin
        // ---------------- reset, with flush/feedback also asserted ----------------
        i_reset = 1'b1; i_flush_req = 1'b1; i_wr_hold = 1'b0;
        i_fb_valid = 1'b1; i_fb_index = 3'd6; i_fb_wdata = 55'h123;
        tick(); tick();
        i_reset = 1'b0; i_flush_req = 1'b0; i_fb_valid = 1'b0;
        #1;
        chk("rst_wr_en",   64'(o_wr_en),      64'(0));
        chk("rst_wr_addr", 64'(o_wr_addr),    64'(0));
        chk("rst_wr_data", 64'(o_wr_data),    64'(0));
        chk("rst_wr_dav",  64'(o_wr_dav),     64'(0));
        chk("rst_drop",    64'(o_fb_drop),    64'(0));
        chk("rst_busy",    64'(o_flush_busy), 64'(0));
        chk("rst_done",    64'(o_flush_done), 64'(0));
        chk("rst_ready",   64'(o_fb_ready),   64'(1));
        tick(); tick();
        chk("rst_no_flush", 64'(o_flush_busy), 64'(0));

        // ---------------- basic flush ----------------
        n0 = obs_q.size(); b0 = busy_cnt; d0 = done_cnt;
        i_flush_req = 1'b1;
        tick();
        i_flush_req = 1'b0;
        #1;
        chk("flush_ready_low", 64'(o_fb_ready), 64'(0));
        wait_idle("flush_timeout");
        chk("flush_nwr",  64'(obs_q.size() - n0), 64'(8));
        chk("flush_busy", 64'(busy_cnt - b0),      64'(9));
        chk("flush_done", 64'(done_cnt - d0),      64'(1));
        if (obs_q.size() - n0 >= 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("flush_addr", 64'(obs_q[n0+k].addr), 64'(k));
                chk("flush_data", 64'(obs_q[n0+k].data), 64'(0));
                chk("flush_dav",  64'(obs_q[n0+k].dav),  64'(0));
                chk("flush_cyc",  64'(obs_q[n0+k].cyc - obs_q[n0].cyc), 64'(k));
            end
        end

        // ---------------- hold during flush ----------------
        tick();
        n0 = obs_q.size(); b0 = busy_cnt; d0 = done_cnt;
        i_flush_req = 1'b1;
        tick();
        i_flush_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        i_wr_hold = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        i_wr_hold = 1'b0;
        wait_idle("hold_timeout");
        chk("hold_nwr",  64'(obs_q.size() - n0), 64'(8));
        chk("hold_busy", 64'(busy_cnt - b0),      64'(12));
        chk("hold_done", 64'(done_cnt - d0),      64'(1));
        if (obs_q.size() - n0 >= 8) begin
            for (int k = 0; k < 8; k++)
                chk("hold_addr", 64'(obs_q[n0+k].addr), 64'(k));
            chk("hold_gap", 64'(obs_q[n0+4].cyc - obs_q[n0+3].cyc), 64'(4));
        end

        // ---------------- reset mid-flush ----------------
        tick();
        n0 = obs_q.size(); d0 = done_cnt;
        i_flush_req = 1'b1;
        tick();
        i_flush_req = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        #1;
        chk("rmf_busy",  64'(o_flush_busy), 64'(0));
        chk("rmf_wr_en", 64'(o_wr_en),      64'(0));
        chk("rmf_addr",  64'(o_wr_addr),    64'(0));
        chk("rmf_data",  64'(o_wr_data),    64'(0));
        chk("rmf_dav",   64'(o_wr_dav),     64'(0));
        chk("rmf_donef", 64'(o_flush_done), 64'(0));
        for (int k = 0; k < 12; k++) tick();
        chk("rmf_no_done", 64'(done_cnt - d0),      64'(0));
        chk("rmf_nwr",     64'(obs_q.size() - n0), 64'(3));

        // ---------------- back-to-back feedback under hold ----------------
        mq.delete();
        n0 = obs_q.size(); r0 = drop_cnt;
        i_wr_hold = 1'b1;
        for (int k = 0; k < 6; k++) begin
            i_fb_valid = 1'b1;
            i_fb_index = 3'($urandom_range(0, 7));
            i_fb_wdata = 55'({$urandom, $urandom});
            #1;
            chk("b2b_ready", 64'(o_fb_ready), 64'(k < 4));
            if (k < 4) begin
                fe.idx = i_fb_index; fe.dat = i_fb_wdata;
                mq.push_back(fe);
            end
            tick();
        end
        i_fb_valid = 1'b0;
        tick(); tick();
        chk("b2b_drops",   64'(drop_cnt - r0),      64'(2));
        chk("b2b_no_wr",   64'(obs_q.size() - n0), 64'(0));
        i_wr_hold = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        chk("b2b_nwr", 64'(obs_q.size() - n0), 64'(4));
        if (obs_q.size() - n0 >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("b2b_addr", 64'(obs_q[n0+k].addr), 64'(mq[k].idx));
                chk("b2b_data", 64'(obs_q[n0+k].data), 64'(mq[k].dat));
                chk("b2b_dav",  64'(obs_q[n0+k].dav),  64'(1));
                chk("b2b_cyc",  64'(obs_q[n0+k].cyc - obs_q[n0].cyc), 64'(k));
            end
        end

        // ---------------- flush collides with feedback ----------------
        n0 = obs_q.size(); r0 = drop_cnt;
        i_wr_hold = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            i_fb_valid = 1'b1; i_fb_index = 3'(k); i_fb_wdata = 55'(k);
            #1;
            chk("col_ready", 64'(o_fb_ready), 64'(1));
            tick();
        end
        i_fb_valid = 1'b1; i_fb_index = 3'd5; i_fb_wdata = 55'h5a5;
        i_flush_req = 1'b1;
        #1;
        chk("col_ready_low", 64'(o_fb_ready), 64'(0));
        tick();
        i_fb_valid = 1'b0; i_flush_req = 1'b0; i_wr_hold = 1'b0;
        wait_idle("col_timeout");
        for (int k = 0; k < 4; k++) tick();
        nd = 0;
        for (int k = n0; k < obs_q.size(); k++) if (obs_q[k].dav) nd++;
        chk("col_drops",  64'(drop_cnt - r0),      64'(1));
        chk("col_dav_wr", 64'(nd),                  64'(0));
        chk("col_nwr",    64'(obs_q.size() - n0), 64'(8));

        // ---------------- randomized traffic vs reference model ----------------
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        mq.delete(); ph = 0; nxt = 0; last_addr = '0; last_data = '0;
        for (int c = 0; c < 400; c++) begin
            i_fb_valid  = 1'($urandom_range(0, 1));
            i_fb_index  = 3'($urandom_range(0, 7));
            i_fb_wdata  = 55'({$urandom, $urandom});
            i_wr_hold   = ($urandom_range(0, 3) == 0);
            i_flush_req = ($urandom_range(0, 49) == 0);
            #1;
            m_ready = (ph == 0) && !i_flush_req && (mq.size() < 4);
            chk("rnd_ready", 64'(o_fb_ready),   64'(m_ready));
            chk("rnd_busy",  64'(o_flush_busy), 64'(ph != 0));
            chk("rnd_done",  64'(o_flush_done), 64'(ph == 2));
            e_wr = 1'b0; e_addr = last_addr; e_data = last_data; e_dav = 1'b0;
            if (ph == 1) begin
                if (!i_wr_hold) begin
                    e_wr = 1'b1; e_addr = 3'(nxt); e_data = '0;
                    if (nxt == ENT - 1) ph = 2;
                    nxt++;
                end
            end else if (ph == 2) begin
                ph = 0;
            end else if (i_flush_req) begin
                mq.delete(); ph = 1; nxt = 0;
            end else begin
                if (mq.size() > 0 && !i_wr_hold) begin
                    fe = mq.pop_front();
                    e_wr = 1'b1; e_addr = fe.idx; e_data = fe.dat; e_dav = 1'b1;
                end
                if (i_fb_valid && m_ready) begin
                    fe.idx = i_fb_index; fe.dat = i_fb_wdata;
                    mq.push_back(fe);
                end
            end
            e_drop = i_fb_valid && !m_ready;
            tick();
            chk("rnd_wr_en", 64'(o_wr_en),   64'(e_wr));
            chk("rnd_addr",  64'(o_wr_addr), 64'(e_addr));
            chk("rnd_data",  64'(o_wr_data), 64'(e_data));
            if (e_wr) chk("rnd_dav", 64'(o_wr_dav), 64'(e_dav));
            chk("rnd_drop",  64'(o_fb_drop), 64'(e_drop));
            last_addr = e_addr; last_data = e_data;
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/zap_btb_maint_ctrl.md
ZAP_BTB_MAINT_CTRL -- requirements
Module: zap_btb_maint_ctrl

Interface
REQ-001 The block SHALL have parameter BP_ENTRIES, default 32'd1024, meaning the BTB RAM depth (power of two, >= 4).
REQ-002 The block SHALL have parameter WR_WDT, default 55, meaning the BTB RAM word width (target 32 + tag + state 2).
REQ-003 The block SHALL have port i_clk, input, 1, the single clock.
REQ-004 The block SHALL have port i_reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port i_flush_req, input, 1, a pulse requesting invalidation of all BTB entries.
REQ-006 The block SHALL have port i_wr_hold, input, 1, which blocks issuing any RAM write this cycle (RAM port borrowed).
REQ-007 The block SHALL have port i_fb_valid, input, 1, a feedback update request.
REQ-008 The block SHALL have port i_fb_index, input, $clog2(BP_ENTRIES), the feedback RAM index.
REQ-009 The block SHALL have port i_fb_wdata, input, WR_WDT, the feedback RAM word.
REQ-010 The block SHALL have port o_fb_ready, output, 1, high when feedback can be accepted.
REQ-011 The block SHALL have port o_fb_drop, output, 1, a one-cycle pulse when valid feedback is discarded.
REQ-012 The block SHALL have ports o_wr_en (1), o_wr_addr ($clog2(BP_ENTRIES)), o_wr_data (WR_WDT) and o_wr_dav (1), outputs forming the registered RAM and DAV write port.
REQ-013 The block SHALL have port o_flush_busy, output, 1, high while a flush is in progress, and used to suppress BTB predictions.
REQ-014 The block SHALL have port o_flush_done, output, 1, a one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, FLUSH and DONE.
REQ-016 In IDLE, i_flush_req SHALL move the FSM to FLUSH on the next cycle, clear the FIFO and load the index counter with 0.
REQ-017 In FLUSH, on each cycle with i_wr_hold=0, the block SHALL issue o_wr_en=1, o_wr_addr=counter, o_wr_data=0 and o_wr_dav=0, then increment the counter.
REQ-018 In FLUSH, on each cycle with i_wr_hold=1, the block SHALL issue no write and hold the counter.
REQ-019 After the write to index BP_ENTRIES-1, the FSM SHALL enter DONE, with counter wrap to 0 not observable.
REQ-020 DONE SHALL last exactly one cycle with o_flush_done=1, then the FSM SHALL return to IDLE.
REQ-021 o_flush_busy SHALL be 1 in FLUSH and DONE, and 0 in IDLE.
REQ-022 i_flush_req in FLUSH or DONE SHALL be ignored; the flush SHALL NOT restart.
REQ-023 Feedback SHALL enter a 4-deep FIFO when i_fb_valid & o_fb_ready.
REQ-024 o_fb_ready SHALL be (state==IDLE) & !i_flush_req & FIFO not full.
REQ-025 o_fb_drop SHALL be asserted the cycle after i_fb_valid & !o_fb_ready, covering full FIFO, flush, and simultaneous flush request.
REQ-026 In IDLE with FIFO non-empty and i_wr_hold=0, the block SHALL pop one entry per cycle and issue o_wr_en=1, o_wr_addr=index, o_wr_data=wdata and o_wr_dav=1.
REQ-027 Feedback accepted into an empty FIFO at cycle N with no hold SHALL appear on the write port at cycle N+1.
REQ-028 A push and a pop in the same cycle SHALL leave the FIFO occupancy unchanged, and a push when full SHALL NOT happen because ready is 0.
REQ-029 Writes SHALL be issued in FIFO order, one write per cycle maximum, and flush writes and feedback writes SHALL never share a cycle.
REQ-030 o_wr_en SHALL be 0 whenever no write is issued, and o_wr_addr and o_wr_data SHALL then hold their previous values.

Reset
REQ-031 Reset SHALL force the FSM to IDLE, the counter to 0, the FIFO to empty, and o_wr_en, o_wr_addr, o_wr_data, o_wr_dav, o_fb_drop, o_flush_busy and o_flush_done all to 0.
REQ-032 Reset during FLUSH SHALL abort the flush without emitting o_flush_done.
REQ-033 Reset SHALL take priority over i_flush_req and i_fb_valid in the same cycle.

Structure
REQ-034 The FSM state enum and the WR_WDT derivation (TAG_WDT, MAX_WDT) SHALL live in the shared package zap_btb_pkg.
REQ-035 The FIFO SHALL be an instance of zap_sync_fifo (WIDTH = index + WR_WDT, DEPTH = 4), with a clear input driven on flush entry.

Verification
REQ-036 Reset mid-flush: BP_ENTRIES=8, flush, reset at write index 3 -> IDLE next cycle, all outputs 0, no o_flush_done.
REQ-037 Basic flush: BP_ENTRIES=8, pulse i_flush_req -> writes to addr 0..7 on 8 consecutive cycles with data 0 and dav 0, then o_flush_done for 1 cycle, with o_flush_busy high for 9 cycles.
REQ-038 Hold during flush: assert i_wr_hold for 3 cycles at index 4 -> no writes for 3 cycles, resume at addr 4, total 12 busy cycles.
REQ-039 Back-to-back feedback: i_fb_valid on 6 consecutive cycles with i_wr_hold=1 -> 4 accepted, o_fb_ready=0 on cycles 5 and 6, o_fb_drop 2 times, then release hold -> 4 writes in order.
REQ-040 Flush collision: i_fb_valid with index 5 coincides with i_flush_req while 2 entries are queued -> 1 drop pulse, queue discarded, no writes to addr 5 with dav=1.
